tick_gen: RTL and testbench

- Parametrised timebase generator for the watch datapath.
- Divides `clk` by a divisor that can be reloaded at run time, without glitches.
- Produces a one-cycle `tick` strobe and a free-running count. An optional near-50% square wave drives display blink and scan.
- One instance per rate (1 Hz seconds, 2 Hz blink, 1 kHz digit scan). Each feeds the timekeeping counters as a clock enable, not as a derived clock.

---
 rtl/tick_pkg.sv | 20 ++
 rtl/tick_gen.sv | 111 +++++++++++
 tb/tb_tick_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tick_pkg.sv
// Shared constants and helpers for the watch timebase generators.
package tick_pkg;

  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned DIV_MIN  = 2;
  localparam int unsigned DIV_1HZ  = CLK_HZ;
  localparam int unsigned DIV_2HZ  = CLK_HZ / 2;
  localparam int unsigned DIV_1KHZ = CLK_HZ / 1000;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pend_e;

  // A divisor below 2 would leave no room for a wrap, so it is raised to 2.
  function automatic logic [31:0] div_clamp(input logic [31:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Reloadable clock-enable timebase: one-cycle tick per divisor period.
// Optional square-wave output enabled by defining TICK_GEN_SQ_EN.
module tick_gen
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DIV_DEFAULT = DIV_1HZ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
`ifdef TICK_GEN_SQ_EN
  ,
  output logic             sq
`endif
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(div_clamp(32'(DIV_DEFAULT)));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_shd_q, div_shd_d;
  pend_e            pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             wrap;
  logic             apply;

  assign wrap = (cnt_q == (div_act_q - CNT_W'(1)));

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    ack_d     = 1'b0;
    apply     = 1'b0;

    if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        apply  = (pend_q == PENDING);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pend_q == PENDING) begin
      // While frozen there is no period in flight, so the swap is immediate.
      cnt_d = '0;
      apply = 1'b1;
    end

    if (apply) begin
      div_act_d = div_shd_q;
      ack_d     = 1'b1;
      pend_d    = IDLE;
    end

    // A fresh load always wins over the apply-clear and targets the next wrap.
    if (div_load) begin
      div_shd_d = CNT_W'(div_clamp(32'(div_val)));
      pend_d    = PENDING;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_act_q <= DIV_RST;
      div_shd_q <= DIV_RST;
      pend_q    <= IDLE;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
    end
  end

  assign cnt     = cnt_q;
  assign tick    = tick_q;
  assign div_ack = ack_q;

`ifdef TICK_GEN_SQ_EN
  logic sq_q, sq_d;

  // Tracks the next count so the wave stays aligned with cnt.
  assign sq_d = (cnt_d < (div_act_d >> 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_q <= 1'b1;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq = sq_q;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen (DIV_DEFAULT=4); covers sq when TICK_GEN_SQ_EN is defined.
module tb_tick_gen;

  localparam int CNT_W = 8;
  localparam int DIV_D = 4;

  logic             clk = 1'b0;
  logic             rst_n, en, div_load;
  logic [CNT_W-1:0] div_val;
  logic             div_ack, tick;
  logic [CNT_W-1:0] cnt;
`ifdef TICK_GEN_SQ_EN
  logic             sq;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: divisor in use, position in period, staged value.
  int m_d, m_cnt, m_shd;
  bit m_pend, m_tick, m_ack, m_sq;

  tick_gen #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_load(div_load), .div_val(div_val),
    .div_ack(div_ack), .tick(tick), .cnt(cnt)
`ifdef TICK_GEN_SQ_EN
    , .sq(sq)
`endif
  );

  always #5 clk = ~clk;

  function automatic int clampf(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_edge();
    int  nshd;
    bit  npend;
    if (!rst_n) begin
      m_d = clampf(DIV_D); m_shd = m_d; m_cnt = 0; m_pend = 0;
      m_tick = 0; m_ack = 0; m_sq = 1;
    end else begin
      nshd = m_shd; npend = m_pend;
      m_tick = 0; m_ack = 0;
      if (en) begin
        if (m_cnt == m_d - 1) begin
          m_cnt = 0; m_tick = 1;
          if (m_pend) begin m_d = m_shd; m_ack = 1; npend = 0; end
        end else m_cnt = m_cnt + 1;
      end else if (m_pend) begin
        m_d = m_shd; m_cnt = 0; m_ack = 1; npend = 0;
      end
      if (div_load) begin nshd = clampf(int'(div_val)); npend = 1; end
      m_shd = nshd; m_pend = npend;
      m_sq = (m_cnt < m_d / 2);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; div_load = 0; div_val = '0;
    repeat (3) step();
    n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", div_ack); end
`ifdef TICK_GEN_SQ_EN
    n_cmp++; if (sq !== 1'b1) begin n_err++; $display("FAIL reset_sq: got %b want 1", sq); end
`endif
    rst_n = 1; en = 1;
    n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL cycle0_cnt: got %0d want 0", cnt); end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++; if (cnt !== 8'(k % 4)) begin n_err++; $display("FAIL count_cnt c%0d: got %0d want %0d", k, cnt, k % 4); end
      n_cmp++; if (tick !== (k % 4 == 0)) begin n_err++; $display("FAIL count_tick c%0d: got %b want %b", k, tick, (k % 4 == 0)); end
      n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL count_ack c%0d: got %b want 0", k, div_ack); end
    end
  endtask

  task automatic test_load();
    step();
    div_load = 1; div_val = 8'd6;
    step();
    div_load = 0;
    step(); step();
    n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL load_wrap_tick: got %b want 1", tick); end
    n_cmp++; if (div_ack !== 1'b1) begin n_err++; $display("FAIL load_wrap_ack: got %b want 1", div_ack); end
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++; if (tick !== (i % 6 == 0)) begin n_err++; $display("FAIL load_d6_tick i%0d: got %b want %b", i, tick, (i % 6 == 0)); end
      n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL load_d6_ack i%0d: got %b want 0", i, div_ack); end
    end
  endtask

  task automatic test_enable();
    step(); step();
    en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (cnt !== 8'd2) begin n_err++; $display("FAIL hold_cnt i%0d: got %0d want 2", i, cnt); end
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL hold_tick i%0d: got %b want 0", i, tick); end
    end
    div_load = 1; div_val = 8'd10;
    step();
    div_load = 0;
    n_cmp++; if (div_ack !== 1'b0 || cnt !== 8'd2) begin n_err++; $display("FAIL idle_stage: ack %b cnt %0d want ack 0 cnt 2", div_ack, cnt); end
    step();
    n_cmp++; if (div_ack !== 1'b1) begin n_err++; $display("FAIL idle_apply_ack: got %b want 1", div_ack); end
    n_cmp++; if (cnt !== 8'd0) begin n_err++; $display("FAIL idle_apply_cnt: got %0d want 0", cnt); end
    en = 1;
    step();
    n_cmp++; if (div_ack !== 1'b0 || cnt !== 8'd1) begin n_err++; $display("FAIL idle_after: ack %b cnt %0d want ack 0 cnt 1", div_ack, cnt); end
  endtask

  task automatic test_back_to_back();
    int n_ack = 0, ack_at = -1;
    div_load = 1; div_val = 8'd5; step();
    div_val = 8'd7; step();
    div_load = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (div_ack) begin n_ack++; if (ack_at < 0) ack_at = i; end
    end
    n_cmp++; if (n_ack != 1) begin n_err++; $display("FAIL overwrite_ack_count: got %0d want 1", n_ack); end
    n_cmp++; if (ack_at != 7) begin n_err++; $display("FAIL overwrite_ack_cycle: got %0d want 7", ack_at); end
    n_cmp++; if (cnt !== 8'd6) begin n_err++; $display("FAIL overwrite_d7_cnt: got %0d want 6", cnt); end
    div_load = 1; div_val = 8'd3; step();
    div_load = 0;
    n_cmp++; if (tick !== 1'b1 || div_ack !== 1'b0) begin n_err++; $display("FAIL wrapload_edge: tick %b ack %b want 1 0", tick, div_ack); end
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (div_ack !== (i == 7) || tick !== (i == 7)) begin n_err++; $display("FAIL wrapload_next i%0d: tick %b ack %b want %b", i, tick, div_ack, (i == 7)); end
    end
  endtask

  task automatic test_clamp();
    bit seen = 0;
    div_load = 1; div_val = 8'd0; step();
    div_val = 8'd1; step();
    div_load = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (div_ack) seen = 1; else step();
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL clamp_ack: got none within 20 cycles want 1"); end
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++; if (tick !== (i % 2 == 0) || cnt !== 8'(i % 2)) begin n_err++; $display("FAIL clamp_d2 i%0d: tick %b cnt %0d want %b %0d", i, tick, cnt, (i % 2 == 0), i % 2); end
    end
  endtask

  task automatic test_reset_mid();
    div_load = 1; div_val = 8'd9; step();
    div_load = 0;
    rst_n = 0; step();
    n_cmp++; if (cnt !== 8'd0 || tick !== 1'b0 || div_ack !== 1'b0) begin n_err++; $display("FAIL midreset: cnt %0d tick %b ack %b want 0 0 0", cnt, tick, div_ack); end
    rst_n = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (tick !== (k % 4 == 0) || div_ack !== 1'b0) begin n_err++; $display("FAIL midreset_d4 c%0d: tick %b ack %b want %b 0", k, tick, div_ack, (k % 4 == 0)); end
    end
  endtask

`ifdef TICK_GEN_SQ_EN
  task automatic test_sq();
    int highs = 0;
    en = 0; div_load = 1; div_val = 8'd5; step();
    div_load = 0; step();
    en = 1;
    n_cmp++; if (sq !== 1'b1) begin n_err++; $display("FAIL sq_start: got %b want 1", sq); end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sq) highs++;
      n_cmp++; if (sq !== ((i % 5) < 2)) begin n_err++; $display("FAIL sq_d5 i%0d: got %b want %b", i, sq, ((i % 5) < 2)); end
    end
    n_cmp++; if (highs != 4) begin n_err++; $display("FAIL sq_duty: got %0d high want 4", highs); end
    repeat (3) step();
    rst_n = 0; step();
    n_cmp++; if (sq !== 1'b1 || cnt !== 8'd0) begin n_err++; $display("FAIL sq_reset: sq %b cnt %0d want 1 0", sq, cnt); end
    rst_n = 1;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 7) == 0);
      div_val  = 8'($urandom_range(0, 9));
      step();
      n_cmp++; if (cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, cnt, m_cnt); end
      n_cmp++; if (tick !== m_tick) begin n_err++; $display("FAIL rnd_tick c%0d: got %b want %b", c, tick, m_tick); end
      n_cmp++; if (div_ack !== m_ack) begin n_err++; $display("FAIL rnd_ack c%0d: got %b want %b", c, div_ack, m_ack); end
`ifdef TICK_GEN_SQ_EN
      n_cmp++; if (sq !== m_sq) begin n_err++; $display("FAIL rnd_sq c%0d: got %b want %b", c, sq, m_sq); end
`endif
    end
    rst_n = 1; en = 1; div_load = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_enable();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
`ifdef TICK_GEN_SQ_EN
    test_sq();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
